// File: rtl/sd_wb_dma_if.sv
// Wishbone B3 classic bus bundle between the SD block DMA master and system memory.
interface sd_wb_dma_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/sd_wb_dma.sv
// Wishbone master that moves one 512-byte SD block between system memory and the
// SD manager's read/write BRAM external ports, handshaking with the manager's ext_* lines.
module sd_wb_dma #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter bit          SWAP_BYTES = 1'b0
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        i_ext_read_act,
  output logic        o_ext_read_go,
  input  logic [31:0] i_ext_read_addr,
  input  logic        i_ext_read_stop,
  input  logic        i_ext_write_act,
  output logic        o_ext_write_done,
  input  logic [31:0] i_ext_write_addr,
  output logic [6:0]  o_bram_rd_ext_addr,
  output logic        o_bram_rd_ext_wren,
  output logic [31:0] o_bram_rd_ext_data,
  output logic [6:0]  o_bram_wr_ext_addr,
  input  logic [31:0] i_bram_wr_ext_q,
  sd_wb_dma_if.master wb,
  output logic        o_busy,
  output logic        o_bus_err
);

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WR, RD_GO, RD_FIN, WR_FETCH, WR_LOAD, WR_REQ, WR_DONE
  } dmaState_t;

  dmaState_t   r_state;
  dmaState_t   w_nextState;
  logic [6:0]  r_wordIdx;
  logic [31:0] r_block;
  logic [31:0] r_rdData;
  logic [6:0]  r_rdAddr;
  logic [31:0] r_wrData;
  logic        r_busErr;
  logic        w_term;
  logic        w_lastWord;
  logic        w_cyc;
  logic [31:0] w_adr;

  function automatic logic [31:0] orderBytes(input logic [31:0] d);
    return SWAP_BYTES ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
  endfunction

  assign w_term     = wb.wb_ack_i | wb.wb_err_i;
  assign w_lastWord = (r_wordIdx == 7'd127);
  assign w_adr      = BASE_ADDR + (r_block << 9) + {23'd0, r_wordIdx, 2'b00};

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // RD_FIN waits for both stop and act low so a stale act cannot start a second read.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_ext_read_act)       w_nextState = RD_REQ;
        else if (i_ext_write_act) w_nextState = WR_FETCH;
      end
      RD_REQ:   if (w_term) w_nextState = RD_WR;
      RD_WR:    w_nextState = w_lastWord ? RD_GO : RD_REQ;
      RD_GO:    if (i_ext_read_stop) w_nextState = RD_FIN;
      RD_FIN:   if (!i_ext_read_stop && !i_ext_read_act) w_nextState = IDLE;
      WR_FETCH: w_nextState = WR_LOAD;
      WR_LOAD:  w_nextState = WR_REQ;
      WR_REQ:   if (w_term) w_nextState = w_lastWord ? WR_DONE : WR_FETCH;
      WR_DONE:  if (!i_ext_write_act) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_cyc              = 1'b0;
    wb.wb_stb_o        = 1'b0;
    wb.wb_we_o         = 1'b0;
    o_bram_rd_ext_wren = 1'b0;
    o_ext_read_go      = 1'b0;
    o_ext_write_done   = 1'b0;
    unique case (r_state)
      RD_REQ:   begin w_cyc = 1'b1; wb.wb_stb_o = 1'b1; end
      RD_WR:    begin w_cyc = 1'b1; o_bram_rd_ext_wren = 1'b1; end
      RD_GO:    o_ext_read_go = 1'b1;
      WR_FETCH: w_cyc = 1'b1;
      WR_LOAD:  w_cyc = 1'b1;
      WR_REQ:   begin w_cyc = 1'b1; wb.wb_stb_o = 1'b1; wb.wb_we_o = 1'b1; end
      WR_DONE:  o_ext_write_done = 1'b1;
      default:  ;
    endcase
  end

  // Captured read data is written to the BRAM even when the slave terminated with err.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_wordIdx <= 7'd0;
      r_block   <= 32'd0;
      r_rdData  <= 32'd0;
      r_rdAddr  <= 7'd0;
      r_wrData  <= 32'd0;
      r_busErr  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_ext_read_act) begin
            r_block  <= i_ext_read_addr;
            r_busErr <= 1'b0;
          end else if (i_ext_write_act) begin
            r_block  <= i_ext_write_addr;
            r_busErr <= 1'b0;
          end
        end
        RD_REQ: begin
          if (w_term) begin
            r_rdData <= orderBytes(wb.wb_dat_i);
            r_rdAddr <= r_wordIdx;
          end
          if (wb.wb_err_i) r_busErr <= 1'b1;
        end
        RD_WR:   r_wordIdx <= r_wordIdx + 7'd1;
        WR_LOAD: r_wrData  <= orderBytes(i_bram_wr_ext_q);
        WR_REQ: begin
          if (w_term)      r_wordIdx <= r_wordIdx + 7'd1;
          if (wb.wb_err_i) r_busErr  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wb.wb_cyc_o         = w_cyc;
  assign wb.wb_adr_o         = w_cyc ? w_adr : 32'd0;
  assign wb.wb_sel_o         = 4'hF;
  assign wb.wb_dat_o         = r_wrData;
  assign o_bram_rd_ext_addr  = r_rdAddr;
  assign o_bram_rd_ext_data  = r_rdData;
  assign o_bram_wr_ext_addr  = r_wordIdx;
  assign o_busy              = (r_state != IDLE);
  assign o_bus_err           = r_busErr;

endmodule

// File: tb/tb_sd_wb_dma.sv
// Scoreboard bench for sd_wb_dma: a straight and a byte-swapping instance run in lockstep
// against one Wishbone slave model and a write-BRAM model.
`timescale 1ns/1ps
module tb_sd_wb_dma;

  typedef struct {
    logic [6:0]  idx;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] dataSwap;
  } exp_t;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        readAct = 1'b0, readStop = 1'b0, writeAct = 1'b0;
  logic [31:0] readAddr = 32'd0, writeAddr = 32'd0;
  logic        go0, go1, done0, done1, wren0, wren1, busy0, busy1, busErr0, busErr1;
  logic [6:0]  rdAddr0, rdAddr1, wrAddr0, wrAddr1;
  logic [31:0] rdData0, rdData1;
  logic [31:0] q0, q1;
  logic [31:0] wrBram [128];

  int          checks = 0;
  int          errors = 0;
  exp_t        rdQ[$];
  exp_t        wrQ[$];
  bit          patMode = 1'b0;
  bit          errEn = 1'b0;
  logic [6:0]  errWord = 7'd0;
  int          waitCnt = 0;

  sd_wb_dma_if wb0();
  sd_wb_dma_if wb1();

  sd_wb_dma #(.BASE_ADDR(32'h0), .SWAP_BYTES(1'b0)) dut0 (
    .clk_50(clk_50), .reset_n(reset_n),
    .i_ext_read_act(readAct), .o_ext_read_go(go0), .i_ext_read_addr(readAddr),
    .i_ext_read_stop(readStop), .i_ext_write_act(writeAct), .o_ext_write_done(done0),
    .i_ext_write_addr(writeAddr), .o_bram_rd_ext_addr(rdAddr0), .o_bram_rd_ext_wren(wren0),
    .o_bram_rd_ext_data(rdData0), .o_bram_wr_ext_addr(wrAddr0), .i_bram_wr_ext_q(q0),
    .wb(wb0.master), .o_busy(busy0), .o_bus_err(busErr0)
  );

  sd_wb_dma #(.BASE_ADDR(32'h0), .SWAP_BYTES(1'b1)) dut1 (
    .clk_50(clk_50), .reset_n(reset_n),
    .i_ext_read_act(readAct), .o_ext_read_go(go1), .i_ext_read_addr(readAddr),
    .i_ext_read_stop(readStop), .i_ext_write_act(writeAct), .o_ext_write_done(done1),
    .i_ext_write_addr(writeAddr), .o_bram_rd_ext_addr(rdAddr1), .o_bram_rd_ext_wren(wren1),
    .o_bram_rd_ext_data(rdData1), .o_bram_wr_ext_addr(wrAddr1), .i_bram_wr_ext_q(q1),
    .wb(wb1.master), .o_busy(busy1), .o_bus_err(busErr1)
  );

  always #10 clk_50 = ~clk_50;

  // Synchronous-read write BRAM: q follows the address one clock later.
  always @(posedge clk_50) begin
    q0 <= wrBram[wrAddr0];
    q1 <= wrBram[wrAddr1];
  end

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Slave model: one wait state per access; err on the chosen read word (raised together with ack).
  always @(negedge clk_50) begin : slaveModel
    logic [31:0] a;
    logic [31:0] rdWord;
    logic        isErr;
    exp_t        e;
    a = wb0.wb_adr_o;
    if (reset_n && wb0.wb_cyc_o && wb0.wb_stb_o) begin
      if (waitCnt == 0) begin
        waitCnt = 1;
        wb0.wb_ack_i = 1'b0; wb0.wb_err_i = 1'b0;
      end else begin
        waitCnt = 0;
        rdWord = patMode ? 32'h1122_3344 : a;
        isErr = errEn && !wb0.wb_we_o && (a[8:2] == errWord);
        wb0.wb_ack_i = 1'b1; wb0.wb_err_i = isErr; wb0.wb_dat_i = rdWord;
        if (wb0.wb_we_o) begin
          if (wrQ.size() == 0) begin
            checkOutput("wrSpurious", wrQ.size(), 1);
          end else begin
            e = wrQ.pop_front();
            checkOutput("wrAdr", a, e.adr);
            checkOutput("wrDat", wb0.wb_dat_o, e.data);
            checkOutput("wrDatSwap", wb1.wb_dat_o, e.dataSwap);
          end
        end
      end
    end else begin
      waitCnt = 0;
      wb0.wb_ack_i = 1'b0; wb0.wb_err_i = 1'b0;
    end
    wb1.wb_ack_i = wb0.wb_ack_i;
    wb1.wb_err_i = wb0.wb_err_i;
    wb1.wb_dat_i = wb0.wb_dat_i;
  end

  always @(negedge clk_50) begin : rdBramMonitor
    exp_t e;
    if (reset_n && wren0) begin
      if (rdQ.size() == 0) begin
        checkOutput("rdSpurious", rdQ.size(), 1);
      end else begin
        e = rdQ.pop_front();
        checkOutput("rdIdx", rdAddr0, e.idx);
        checkOutput("rdDat", rdData0, e.data);
        checkOutput("rdDatSwap", rdData1, e.dataSwap);
        checkOutput("rdWrenSwap", wren1, 1);
      end
    end
  end

  task automatic applyStimulus(input bit isWrite, input logic [31:0] block);
    exp_t e;
    for (int i = 0; i < 128; i++) begin
      e.idx = i[6:0];
      e.adr = (block << 9) + 32'(i * 4);
      if (isWrite) e.data = 32'hA500_0000 | 32'(i);
      else         e.data = patMode ? 32'h1122_3344 : e.adr;
      e.dataSwap = bswap(e.data);
      if (isWrite) wrQ.push_back(e);
      else         rdQ.push_back(e);
    end
    if (isWrite) begin writeAddr = block; writeAct = 1'b1; end
    else         begin readAddr = block; readAct = 1'b1; end
  endtask

  function automatic bit condMet(input int sel);
    case (sel)
      0:       return go0 === 1'b1;
      1:       return done0 === 1'b1;
      default: return wrAddr0 === 7'd60;
    endcase
  endfunction

  task automatic waitFor(input int sel, input string tag);
    int n = 0;
    while (!condMet(sel) && n < 3000) begin
      @(negedge clk_50);
      n++;
    end
    checkOutput(tag, 32'(condMet(sel)), 1);
  endtask

  task automatic finishRead(input bit expectIdle);
    readStop = 1'b1;
    @(negedge clk_50);
    checkOutput("goFall", go0, 0);
    checkOutput("finBusy", busy0, 1);
    readStop = 1'b0;
    readAct = 1'b0;
    @(negedge clk_50);
    if (expectIdle) checkOutput("rdIdle", busy0, 0);
  endtask

  task automatic finishWrite();
    repeat (3) @(negedge clk_50);
    checkOutput("doneHeld", done0, 1);
    writeAct = 1'b0;
    @(negedge clk_50);
    checkOutput("doneFall", done0, 0);
    checkOutput("wrIdle", busy0, 0);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("[TB] FAIL watchdog simulation time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) wrBram[i] = 32'hA500_0000 | 32'(i);
    wb0.wb_ack_i = 1'b0; wb0.wb_err_i = 1'b0; wb0.wb_dat_i = 32'd0;
    wb1.wb_ack_i = 1'b0; wb1.wb_err_i = 1'b0; wb1.wb_dat_i = 32'd0;
    repeat (3) @(negedge clk_50);
    checkOutput("rstBusy", busy0, 0);
    checkOutput("rstCyc", wb0.wb_cyc_o, 0);
    checkOutput("rstStb", wb0.wb_stb_o, 0);
    checkOutput("rstSel", wb0.wb_sel_o, 4'hF);
    checkOutput("rstAdr", wb0.wb_adr_o, 0);
    checkOutput("rstGo", go0, 0);
    checkOutput("rstDone", done0, 0);
    checkOutput("rstWren", wren0, 0);
    checkOutput("rstBusErr", busErr0, 0);
    reset_n = 1'b1;
    @(negedge clk_50);

    $display("[TB] read block 3");
    applyStimulus(1'b0, 32'd3);
    waitFor(0, "rdGoRise");
    checkOutput("rdAllWritten", rdQ.size(), 0);
    checkOutput("rdBusErr", busErr0, 0);
    finishRead(1'b1);

    $display("[TB] write block 1");
    applyStimulus(1'b1, 32'd1);
    waitFor(1, "wrDoneRise");
    checkOutput("wrAllIssued", wrQ.size(), 0);
    finishWrite();

    $display("[TB] read with fixed pattern for byte swap");
    patMode = 1'b1;
    applyStimulus(1'b0, 32'd0);
    waitFor(0, "swGoRise");
    checkOutput("swAllWritten", rdQ.size(), 0);
    finishRead(1'b1);
    patMode = 1'b0;

    $display("[TB] read with err on word 5");
    errEn = 1'b1; errWord = 7'd5;
    applyStimulus(1'b0, 32'd2);
    waitFor(0, "errGoRise");
    checkOutput("errAllWritten", rdQ.size(), 0);
    checkOutput("errBusErr", busErr0, 1);
    checkOutput("errBusErrSwap", busErr1, 1);
    finishRead(1'b1);
    errEn = 1'b0;
    applyStimulus(1'b1, 32'd0);
    @(negedge clk_50);
    checkOutput("errCleared", busErr0, 0);
    checkOutput("errClrBusy", busy0, 1);
    waitFor(1, "errWrDone");
    finishWrite();

    $display("[TB] reset during write");
    applyStimulus(1'b1, 32'd4);
    waitFor(2, "reach60");
    #2;
    reset_n = 1'b0;
    writeAct = 1'b0;
    #1;
    checkOutput("midRstCyc", wb0.wb_cyc_o, 0);
    checkOutput("midRstStb", wb0.wb_stb_o, 0);
    checkOutput("midRstDone", done0, 0);
    checkOutput("midRstBusy", busy0, 0);
    checkOutput("midRstIdx", wrAddr0, 0);
    wrQ.delete();
    @(negedge clk_50);
    reset_n = 1'b1;
    @(negedge clk_50);
    applyStimulus(1'b1, 32'd5);
    waitFor(1, "rstWrDone");
    checkOutput("rstWrAll", wrQ.size(), 0);
    finishWrite();

    $display("[TB] simultaneous read and write requests");
    applyStimulus(1'b0, 32'd6);
    applyStimulus(1'b1, 32'd7);
    waitFor(0, "bothGoRise");
    checkOutput("bothRdFirst", wrQ.size(), 128);
    checkOutput("bothRdAll", rdQ.size(), 0);
    finishRead(1'b0);
    waitFor(1, "bothWrDone");
    checkOutput("bothWrAll", wrQ.size(), 0);
    finishWrite();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_wb_dma.md
Name: sd_wb_dma

Overview:
- Wishbone B3 classic master that services the SD manager's external block-transfer handshakes on clk_50.
- Read request: fetches one 512-byte block (128 x 32-bit words) from system memory and writes it into the read BRAM's external port, then signals ext_read_go.
- Write request: drains the write BRAM's external port to system memory, then signals ext_write_done.
- Sits directly downstream of the SD manager's ext_* interface; nothing else drives those BRAM ports.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of block 0 in Wishbone space.
- SWAP_BYTES, 0, when 1 reverse byte order of every 32-bit word in both directions.

Ports:
- clk_50  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ext_read_act  in  1  manager requests a block read.
- ext_read_go  out  1  block read complete, BRAM valid.
- ext_read_addr  in  32  block number to read.
- ext_read_stop  in  1  manager acknowledges go.
- ext_write_act  in  1  manager requests a block write.
- ext_write_done  out  1  block write complete.
- ext_write_addr  in  32  block number to write.
- bram_rd_ext_addr  out  7  word index into read BRAM.
- bram_rd_ext_wren  out  1  read-BRAM write strobe.
- bram_rd_ext_data  out  32  read-BRAM write data.
- bram_wr_ext_addr  out  7  word index into write BRAM.
- bram_wr_ext_q  in  32  write-BRAM data, valid 1 cycle after address.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle, strobe, write enable.
- wb_adr_o  out  32  byte address.
- wb_sel_o  out  4  always 4'hF.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i  in  1  Wishbone termination.
- busy  out  1  FSM not in IDLE.
- bus_err  out  1  sticky, set by any wb_err_i during a block; cleared at start of next block.

Behaviour:
- Reset (asynchronous, on reset_n low; also mid-transfer): state IDLE; word_idx 0.
  - All outputs 0, except wb_sel_o = 4'hF.
  - An interrupted Wishbone cycle is abandoned (cyc/stb drop immediately).
- Address: wb_adr_o = BASE_ADDR + (block << 9) + (word_idx << 2), truncated to 32 bits.
  - block is latched from ext_*_addr when leaving IDLE.
- IDLE:
  - If ext_read_act, latch ext_read_addr, clear bus_err, go to RD_REQ.
  - Else if ext_write_act, latch ext_write_addr, clear bus_err, go to WR_FETCH.
  - Read wins if both are high.
- RD_REQ: cyc = stb = 1, we = 0. Hold until ack or err.
  - On termination: capture wb_dat_i (byte-swapped if SWAP_BYTES) into bram_rd_ext_data, set bram_rd_ext_addr = word_idx, stb = 0. Go to RD_WR.
  - err additionally sets bus_err; the captured data is written anyway.
- RD_WR: bram_rd_ext_wren = 1 for exactly this cycle.
  - If word_idx = 127: drop cyc, go to RD_GO.
  - Else word_idx+1, back to RD_REQ (stb reasserts next cycle).
  - Minimum 2 cycles per word.
- RD_GO: ext_read_go = 1. Hold until ext_read_stop = 1, then go = 0 and go to RD_FIN.
- RD_FIN: wait until ext_read_stop = 0 and ext_read_act = 0, then IDLE. This prevents re-triggering on the stale act.
- WR_FETCH: bram_wr_ext_addr = word_idx; wait 1 cycle for q. Go to WR_REQ.
- WR_REQ: wb_dat_o = bram_wr_ext_q (swapped if SWAP_BYTES), registered on entry; cyc = stb = we = 1. Hold until ack or err.
  - err sets bus_err.
  - On termination, stb = 0.
    - If word_idx = 127: drop cyc, go to WR_DONE.
    - Else word_idx+1, go to WR_FETCH.
  - Minimum 3 cycles per word.
- WR_DONE: ext_write_done = 1. Hold until ext_write_act = 0, then done = 0 and IDLE.
- ext_write_done is 0 in every other state, so the manager always sees done low before the rising edge.
- word_idx wraps 127 -> 0 on block completion only.
- ack and err in the same cycle: treated as err.
- ext_*_act dropping mid-block is ignored; the block always completes.
- Rising-edge detection of go/done is the manager's job; this block holds levels as above.

Test Plan:
- Read, block 3, BASE_ADDR 0, slave returns data = address, ack after 1 wait -> wb_adr_o runs 0x600..0x7FC; 128 wren pulses at addr 0..127 with data 0x600..0x7FC; go rises after last wren, falls the cycle after stop rises.
- Write, block 1, write BRAM preloaded with word i = 0xA5000000 | i -> 128 Wishbone writes at 0x200..0x3FC with matching data; done held until act falls.
- SWAP_BYTES = 1: slave returns 0x11223344 -> BRAM receives 0x44332211; write path swaps symmetrically.
- wb_err_i on word 5 of a read -> bus_err = 1, transfer still completes 128 words, go asserted; bus_err clears when the next act is accepted.
- reset_n low at word 60 of a write -> cyc/stb/done/busy 0 immediately; after release, a new act restarts at word 0.
- ext_read_act and ext_write_act both high in IDLE -> read serviced first; write starts after RD_FIN returns to IDLE with write act still high.
